// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// It holds the PC register, drives a handshaked instruction-memory port that
// may insert wait states, and keeps a one-entry hold buffer. It also holds
// the IF/ID pipeline register that feeds decode.
//
// Optional build macro: IF_PERF_CNT_EN
//   When it is defined, the stage adds the FetchCntF and WaitCntF performance
//   counters and their output ports.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   PCSrcD, PCBranchD     branch/jump taken in decode and its target
//   StallF, StallD        hazard unit: freeze PC / hold IF/ID
//   FlushD                hazard unit: load a bubble into IF/ID
//   ImemReqF, ImemAddrF   memory request valid and address (always PCF)
//   ImemDataF, ImemReadyF read data and completion strobe
//   PCF, PCPlus4F         current fetch PC and its sequential successor
//   InstrD, PCD, PCPlus4D IF/ID instruction, PC and PC+PC_INC
//   ValidD                IF/ID holds a real instruction (not a bubble)
//   FetchCntF, WaitCntF   (IF_PERF_CNT_EN only) consumed words, wait cycles
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_INC   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCSrcD,
    input  logic [ADDR_W-1:0] PCBranchD,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    output logic              ImemReqF,
    output logic [ADDR_W-1:0] ImemAddrF,
    input  logic [DATA_W-1:0] ImemDataF,
    input  logic              ImemReadyF,
    output logic [ADDR_W-1:0] PCF,
    output logic [ADDR_W-1:0] PCPlus4F,
    output logic [DATA_W-1:0] InstrD,
    output logic [ADDR_W-1:0] PCD,
    output logic [ADDR_W-1:0] PCPlus4D,
    output logic              ValidD
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       FetchCntF,
    output logic [31:0]       WaitCntF
`endif
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    // S_RST  : one idle cycle after reset, no request
    // S_REQ  : request outstanding at PCF
    // S_HOLD : word captured in the hold buffer, waiting for decode to take it
    // S_DRAIN: redirect arrived mid-request; finish and discard the old access
    localparam logic [1:0] S_RST   = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pending;
    logic [ADDR_W-1:0] pending_next;
    logic [DATA_W-1:0] hold_buf;
    logic [DATA_W-1:0] hold_next;

    logic              redirect;
    logic              avail;
    logic              consume;
    logic [DATA_W-1:0] word;

    // A redirect while decode is stalled would lose the branch instruction's
    // own effect, so decode re-issues it once StallD drops.
    assign redirect = PCSrcD & ~StallD;

    // A word is available from the live memory response or from the buffer.
    assign avail   = ((state == S_REQ) & ImemReadyF) | (state == S_HOLD);
    assign consume = avail & ~StallF & ~StallD & ~FlushD & ~redirect;
    assign word    = (state == S_HOLD) ? hold_buf : ImemDataF;

    // The address is simply PCF. PCF only moves when the request completes
    // or when no request is outstanding, so the address stays stable while
    // the memory is busy.
    assign ImemReqF  = (state == S_REQ) | (state == S_DRAIN);
    assign ImemAddrF = PCF;
    assign PCPlus4F  = PCF + INC;

    // ------------------------------------------------------------------
    // Fetch FSM and PC selection
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        pc_next      = PCF;
        pending_next = pending;
        hold_next    = hold_buf;
        case (state)
            S_RST: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (ImemReadyF) begin
                    if (redirect) begin
                        // Word at the fall-through PC is dropped.
                        pc_next = PCBranchD;
                    end else if (consume) begin
                        pc_next = PCPlus4F;
                    end else begin
                        // Decode cannot take it now; park it so the
                        // request can be retired without losing the word.
                        hold_next  = ImemDataF;
                        state_next = S_HOLD;
                    end
                end else if (redirect) begin
                    // The request cannot be withdrawn, so remember the
                    // target and let the old access finish first.
                    pending_next = PCBranchD;
                    state_next   = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_next    = PCBranchD;
                    state_next = S_REQ;
                end else if (consume) begin
                    pc_next    = PCPlus4F;
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (ImemReadyF) begin
                    // A redirect in this very cycle is newer than pending.
                    pc_next    = redirect ? PCBranchD : pending;
                    state_next = S_REQ;
                end else if (redirect) begin
                    pending_next = PCBranchD;
                end
            end
            default: begin
                state_next = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RST;
            PCF      <= RESET_PC;
            pending  <= '0;
            hold_buf <= '0;
        end else begin
            state    <= state_next;
            PCF      <= pc_next;
            pending  <= pending_next;
            hold_buf <= hold_next;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // Flush beats stall. A bubble clears InstrD to NOP and ValidD but keeps
    // the PC fields, which decode ignores when ValidD is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= '0;
            ValidD <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCD      <= PCD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else if (consume) begin
            InstrD   <= word;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            ValidD   <= 1'b1;
        end else begin
            InstrD <= '0;
            ValidD <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters: words handed to decode, and cycles spent with a
    // request outstanding that the memory did not complete. Both wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FetchCntF <= '0;
            WaitCntF  <= '0;
        end else begin
            if (consume)
                FetchCntF <= FetchCntF + 32'd1;
            if (ImemReqF & ~ImemReadyF)
                WaitCntF <= WaitCntF + 32'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Parametrised instruction-fetch stage for the 5-stage MIPS pipeline: PC register, handshaked instruction-memory port with wait states, one-entry hold buffer, and the IF/ID pipeline register.
- Takes branch redirects from D, stall/flush from the hazard unit.
- Delivers InstrD/PCD/PCPlus4D/ValidD to decode.
- Supports multi-cycle memories without losing or duplicating instructions.

Parameters:
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset (ADDR_W bits)
PC_INC, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
PCSrcD  in  1  branch/jump taken, resolved in D
PCBranchD  in  ADDR_W  redirect target
StallF  in  1  hazard unit: do not advance PC
StallD  in  1  hazard unit: hold IF/ID register
FlushD  in  1  load bubble into IF/ID
ImemReqF  out  1  memory request valid
ImemAddrF  out  ADDR_W  memory address (=PCF)
ImemDataF  in  DATA_W  read data, valid when ImemReadyF=1
ImemReadyF  in  1  request completes this cycle
PCF  out  ADDR_W  current fetch PC
PCPlus4F  out  ADDR_W  PCF+PC_INC
InstrD  out  DATA_W  IF/ID instruction
PCD  out  ADDR_W  IF/ID PC
PCPlus4D  out  ADDR_W  IF/ID PC+PC_INC
ValidD  out  1  IF/ID holds a real instruction

Behaviour:
- Clock clk, reset rst_n: one clock; reset is asynchronous and active-low.
- Reset values: PCF=RESET_PC, state=S_RST, InstrD=0, PCD=0, PCPlus4D=0, ValidD=0, hold buffer=0, pending target=0, ImemReqF=0.
- Reset mid-request abandons the transaction; memory must tolerate the withdrawn request.
- Definitions:
  - redirect = PCSrcD & ~StallD.
  - avail = (S_REQ & ImemReadyF) | S_HOLD.
  - consume = avail & ~StallF & ~StallD & ~FlushD & ~redirect.
- Memory protocol: ImemAddrF=PCF whenever ImemReqF=1. Once ImemReqF is asserted, ImemAddrF is held stable until ImemReadyF=1; a request is never withdrawn. Zero-wait memory (ImemReadyF tied 1) gives one instruction per cycle.
- PCPlus4F = PCF+PC_INC, modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0.
- FSM:
  - S_RST: ImemReqF=0; next cycle goes to S_REQ. Inputs ignored.
  - S_REQ: ImemReqF=1. Transitions, in priority order:
    - ImemReadyF & redirect: PCF<=PCBranchD, data dropped, stay.
    - ImemReadyF & consume: IF/ID<=word, PCF<=PCPlus4F, stay.
    - ImemReadyF otherwise: buffer<=ImemDataF, go to S_HOLD.
    - ~ImemReadyF & redirect: pending<=PCBranchD, go to S_DRAIN.
  - S_HOLD: ImemReqF=0.
    - redirect: PCF<=PCBranchD, buffer dropped, go to S_REQ.
    - consume: IF/ID<=buffer, PCF<=PCPlus4F, go to S_REQ.
  - S_DRAIN: ImemReqF=1 at the old PCF.
    - Further redirect: pending<=PCBranchD (latest wins).
    - ImemReadyF: data discarded; PCF<=(redirect this cycle ? PCBranchD : pending); go to S_REQ.
- IF/ID register:
  - FlushD=1: bubble regardless of StallD.
  - Else StallD=1: hold all fields.
  - Else consume: InstrD<=word, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
  - Else bubble.
  - Bubble: InstrD=0 (NOP), ValidD=0, PCD/PCPlus4D unchanged.
- Redirect always bubbles the IF/ID slot; fetch restarts at the target the following cycle, giving a 1-cycle branch penalty with zero-wait memory.
- Each instruction word enters IF/ID at most once; no word is skipped across stalls or wait states.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs FetchCntF[31:0] and WaitCntF[31:0], both reset to 0.
  - FetchCntF increments on each consume.
  - WaitCntF increments each cycle ImemReqF=1 & ImemReadyF=0.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, ImemReadyF=1, memory[i]=i, no stalls -> ImemReqF=0 one cycle; then PCF 0,4,8,...; InstrD/PCD sequence 0/0, 1/4, 2/8 one cycle behind; ValidD=1 from the 2nd fetch cycle.
- ImemReadyF low 3 cycles at PCF=8 -> ImemAddrF holds 8; ValidD=0 those cycles; word 2 delivered once; WaitCntF=3 with IF_PERF_CNT_EN.
- StallF=StallD=1 for 2 cycles while word at 0xC completes -> S_HOLD; IF/ID holds 0x8; after release InstrD=word(0xC), PCF=0x10; no duplicates.
- PCSrcD=1, PCBranchD=0x40 during a wait state at PCF=0x10 -> request at 0x10 completes and is discarded; next ImemAddrF=0x40; ValidD=0 for discarded slots.
- FlushD=1 with StallD=1 -> ValidD=0, InstrD=0 next cycle; the pending word is delivered when FlushD drops.
- RESET_PC=0xBFC00000 and PCF=0xFFFFFFFC -> reset loads 0xBFC00000; PCPlus4F wraps to 0.
